// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: drives the instruction memory handshake and feeds the IF/ID register,
// with a one-entry skid buffer for decode back-pressure and redirect/drain handling.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc4,
  output logic [5:0]  id_op
);

  typedef enum logic [1:0] {StIdle, StFetch, StFull, StDrain} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] drain_addr_q, drain_addr_d;
  logic        skid_valid_q, skid_valid_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc4_q, skid_pc4_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic [31:0] id_pc4_q, id_pc4_d;

  logic        consume;
  logic        xfer;
  logic [31:0] pc_plus4;
  logic        unused_redirect_lsb;

  assign unused_redirect_lsb = ^redirect_pc[1:0];

  assign imem_req  = (state_q == StFetch) || (state_q == StDrain);
  // While draining, pc already holds the redirect target; the bus keeps the abandoned address.
  assign imem_addr = (state_q == StDrain) ? drain_addr_q : pc_q;
  assign consume   = id_valid_q & id_ready;
  assign xfer      = imem_req & imem_ack;
  assign pc_plus4  = pc_q + 32'd4;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    skid_valid_d = skid_valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc4_d   = skid_pc4_q;
    id_valid_d   = id_valid_q;
    id_instr_d   = id_instr_q;
    id_pc4_d     = id_pc4_q;

    if (redirect_valid) begin
      id_valid_d   = 1'b0;
      id_instr_d   = 32'h0000_0000;
      skid_valid_d = 1'b0;
      pc_d         = {redirect_pc[31:2], 2'b00};
      unique case (state_q)
        StFetch: begin
          if (!imem_ack) begin
            state_d      = StDrain;
            drain_addr_d = pc_q;
          end
        end
        // An ack on the redirect cycle ends the drain; otherwise keep waiting for it.
        StDrain: state_d = imem_ack ? StFetch : StDrain;
        default: state_d = StFetch;
      endcase
    end else begin
      if (consume) begin
        id_valid_d = 1'b0;
        id_instr_d = 32'h0000_0000;
      end
      unique case (state_q)
        StIdle: state_d = StFetch;
        StFetch: begin
          if (xfer) begin
            pc_d = pc_plus4;
            if (!id_valid_q || consume) begin
              id_valid_d = 1'b1;
              id_instr_d = imem_rdata;
              id_pc4_d   = pc_plus4;
            end else begin
              skid_valid_d = 1'b1;
              skid_instr_d = imem_rdata;
              skid_pc4_d   = pc_plus4;
              state_d      = StFull;
            end
          end
        end
        StFull: begin
          if (consume) begin
            id_valid_d   = skid_valid_q;
            id_instr_d   = skid_instr_q;
            id_pc4_d     = skid_pc4_q;
            skid_valid_d = 1'b0;
            state_d      = StFetch;
          end
        end
        StDrain: begin
          if (xfer) begin
            state_d = StFetch;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      pc_q         <= RESET_PC;
      drain_addr_q <= RESET_PC;
      skid_valid_q <= 1'b0;
      skid_instr_q <= 32'h0000_0000;
      skid_pc4_q   <= 32'h0000_0000;
      id_valid_q   <= 1'b0;
      id_instr_q   <= 32'h0000_0000;
      id_pc4_q     <= 32'h0000_0000;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
      skid_valid_q <= skid_valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc4_q   <= skid_pc4_d;
      id_valid_q   <= id_valid_d;
      id_instr_q   <= id_instr_d;
      id_pc4_q     <= id_pc4_d;
    end
  end

  assign id_valid = id_valid_q;
  assign id_instr = id_instr_q;
  assign id_pc4   = id_pc4_q;
  assign id_op    = id_instr_q[31:26];

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: streaming, back-pressure, drain, redirect, wrap and reset.
module tb_if_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc4;
  logic [5:0]  id_op;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  if_fetch_stage #(
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .id_ready      (id_ready),
    .id_valid      (id_valid),
    .id_instr      (id_instr),
    .id_pc4        (id_pc4),
    .id_op         (id_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"},   {31'd0, imem_req}, 32'd0);
    chk({tag, "_addr"},  imem_addr,         32'h0000_0000);
    chk({tag, "_valid"}, {31'd0, id_valid}, 32'd0);
    chk({tag, "_instr"}, id_instr,          32'd0);
    chk({tag, "_op"},    {26'd0, id_op},    32'd0);
    chk({tag, "_pc4"},   id_pc4,            32'd0);
  endtask

  initial begin
    rst_n          = 1'b1;
    imem_ack       = 1'b0;
    imem_rdata     = 32'd0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    id_ready       = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    chk_reset_outputs("rst0");
    imem_ack = 1'b1;
    tick();
    tick();
    chk("rst_hold_req", {31'd0, imem_req}, 32'd0);

    // Streaming with ack held and decode always ready
    @(negedge clk);
    rst_n      = 1'b1;
    imem_rdata = 32'h2008_0005;
    id_ready   = 1'b1;
    tick();
    chk("s_req1",   {31'd0, imem_req}, 32'd1);
    chk("s_addr0",  imem_addr, 32'h0);
    chk("s_vld0",   {31'd0, id_valid}, 32'd0);
    tick();
    chk("s_instr",  id_instr, 32'h2008_0005);
    chk("s_op",     {26'd0, id_op}, {26'd0, 6'b001000});
    chk("s_pc4",    id_pc4, 32'd4);
    chk("s_addr4",  imem_addr, 32'h4);
    tick();
    chk("s_pc4_8",  id_pc4, 32'd8);
    chk("s_addr8",  imem_addr, 32'h8);

    // Decode stalls three cycles: one word goes to skid, fetch stops
    imem_rdata = 32'hA1A1_0001;
    id_ready   = 1'b0;
    tick();
    chk("bp_req0",  {31'd0, imem_req}, 32'd0);
    chk("bp_hold_i", id_instr, 32'h2008_0005);
    chk("bp_hold_p", id_pc4, 32'd8);
    imem_rdata = 32'hBAD0_BAD0;
    tick();
    tick();
    chk("bp_req0b", {31'd0, imem_req}, 32'd0);
    chk("bp_hold_p2", id_pc4, 32'd8);
    chk("bp_vld", {31'd0, id_valid}, 32'd1);
    imem_rdata = 32'hB2B2_0002;
    id_ready   = 1'b1;
    tick();
    chk("bp_skid_i", id_instr, 32'hA1A1_0001);
    chk("bp_skid_p", id_pc4, 32'd12);
    chk("bp_addr12", imem_addr, 32'hC);
    chk("bp_req1", {31'd0, imem_req}, 32'd1);
    tick();
    chk("bp_next_i", id_instr, 32'hB2B2_0002);
    chk("bp_next_p", id_pc4, 32'd16);

    // Redirect with ack withheld at 0x10 -> drain
    imem_ack       = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h43;
    tick();
    redirect_valid = 1'b0;
    chk("dr_req",   {31'd0, imem_req}, 32'd1);
    chk("dr_addr",  imem_addr, 32'h10);
    chk("dr_vld",   {31'd0, id_valid}, 32'd0);
    chk("dr_instr", id_instr, 32'd0);
    tick();
    chk("dr_addr2", imem_addr, 32'h10);
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    tick();
    chk("dr_new",   imem_addr, 32'h40);
    chk("dr_disc",  {31'd0, id_valid}, 32'd0);

    // Redirect coincident with ack at 0x40, then stream one word at 0x1C
    redirect_valid = 1'b1;
    redirect_pc    = 32'h1C;
    tick();
    redirect_valid = 1'b0;
    chk("ra_addr",  imem_addr, 32'h1C);
    chk("ra_vld",   {31'd0, id_valid}, 32'd0);
    imem_rdata = 32'hC3C3_0003;
    tick();
    chk("ra_instr", id_instr, 32'hC3C3_0003);
    chk("ra_addr20", imem_addr, 32'h20);
    imem_rdata     = 32'hD4D4_0004;
    id_ready       = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    tick();
    redirect_valid = 1'b0;
    chk("rb_vld",   {31'd0, id_valid}, 32'd0);
    chk("rb_instr", id_instr, 32'd0);
    chk("rb_addr",  imem_addr, 32'h100);

    // Redirect inside drain retargets pc; then wrap at the top of memory
    imem_ack       = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    tick();
    redirect_pc = 32'hFFFF_FFFF;
    tick();
    redirect_valid = 1'b0;
    chk("w_drain_addr", imem_addr, 32'h100);
    chk("w_drain_req", {31'd0, imem_req}, 32'd1);
    imem_ack = 1'b1;
    tick();
    chk("w_addr_top", imem_addr, 32'hFFFF_FFFC);
    imem_rdata = 32'hFC00_0001;
    id_ready   = 1'b1;
    tick();
    chk("w_pc4",    id_pc4, 32'd0);
    chk("w_addr0",  imem_addr, 32'd0);
    chk("w_instr",  id_instr, 32'hFC00_0001);
    chk("w_op",     {26'd0, id_op}, {26'd0, 6'b111111});

    // Fill skid, drain it, enter DRAIN at 0x4, then assert reset mid-cycle
    imem_rdata = 32'hF6F6_0006;
    id_ready   = 1'b0;
    tick();
    imem_ack = 1'b0;
    id_ready = 1'b1;
    tick();
    chk("rd_instr", id_instr, 32'hF6F6_0006);
    chk("rd_pc4",   id_pc4, 32'd4);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h80;
    tick();
    redirect_valid = 1'b0;
    chk("rd_addr",  imem_addr, 32'h4);
    chk("rd_req",   {31'd0, imem_req}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_outputs("rst_drain");
    imem_ack   = 1'b1;
    imem_rdata = 32'h1234_5678;
    tick();
    chk("rst_drain_req", {31'd0, imem_req}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_addr", imem_addr, 32'h0);
    chk("post_req",  {31'd0, imem_req}, 32'd1);
    chk("post_vld",  {31'd0, id_valid}, 32'd0);
    tick();
    chk("post_instr", id_instr, 32'h1234_5678);
    chk("post_pc4",   id_pc4, 32'd4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
IF_FETCH_STAGE -- requirements
Module: if_fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, address of the first fetch after reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 imem_req  output  1  fetch request; a transfer completes on a cycle with imem_req & imem_ack.
REQ-005 imem_addr  output  32  fetch address; held stable while imem_req & !imem_ack.
REQ-006 imem_ack  input  1  memory accepts the request; imem_rdata valid the same cycle.
REQ-007 imem_rdata  input  32  fetched instruction word.
REQ-008 redirect_valid  input  1  one-cycle branch/jump redirect from a later stage.
REQ-009 redirect_pc  input  32  redirect target.
REQ-010 id_ready  input  1  decode stage consumes the IF/ID entry this cycle if id_valid.
REQ-011 id_valid  output  1  IF/ID entry holds a live instruction.
REQ-012 id_instr  output  32  IF/ID instruction word.
REQ-013 id_pc4  output  32  address of id_instr plus 4.
REQ-014 id_op  output  6  id_instr[31:26], combinational from the IF/ID register; drives the main opcode decoder.

Function
REQ-015 State machine with states IDLE, FETCH, FULL, DRAIN; imem_req = 1 in FETCH and DRAIN only.
REQ-016 IDLE -> FETCH unconditionally on the first edge after reset release.
REQ-017 In FETCH, imem_addr = pc; on req & ack, the word is accepted and pc <= pc + 4, with modulo-2^32 wrap (32'hFFFF_FFFC -> 0).
REQ-018 Accepted word routing: loaded into IF/ID if IF/ID is empty or consumed the same cycle; otherwise loaded into a one-entry skid buffer and state -> FULL.
REQ-019 In FULL, imem_req = 0; when IF/ID is consumed, the skid entry moves into IF/ID the next edge and state -> FETCH.
REQ-020 IF/ID consumed with no replacement: id_valid <= 0 and id_instr <= 32'h0000_0000, which is a NOP with op 000000.
REQ-021 id_valid, id_instr and id_pc4 stay unchanged while id_valid & !id_ready, with no redirect.
REQ-022 Redirect has priority over every other event: IF/ID and skid are flushed (id_valid <= 0, id_instr <= 0) and pc <= {redirect_pc[31:2], 2'b00}.
REQ-023 Redirect in FETCH with imem_req & !imem_ack: state -> DRAIN; imem_addr holds the old address until ack; the returned word is discarded; then state -> FETCH at the new pc.
REQ-024 Redirect in FETCH on the same cycle as ack: the acked word is discarded and state stays FETCH at the new pc.
REQ-025 Redirect in FULL or IDLE: state -> FETCH at the new pc.
REQ-026 Redirect in DRAIN: pc is overwritten with the latest target and state stays DRAIN.
REQ-027 Each fetched word appears on IF/ID at most once, in program order; no word is dropped except by flush.
REQ-028 Latency: data acked in a cycle with IF/ID free is visible on id_instr/id_valid after the next rising edge.

Reset
REQ-029 While rst_n = 0, immediately and independent of clk: state = IDLE, pc = RESET_PC, imem_req = 0, imem_addr = RESET_PC, skid empty, id_valid = 0, id_instr = 0, id_op = 0, id_pc4 = 0.
REQ-030 Reset asserted mid-transfer or mid-drain abandons the outstanding request; no word is delivered after reset release until a new FETCH handshake completes.

Verification
REQ-031 Reset release, ack held 1, rdata = 0x2008_0005, id_ready = 1 -> imem_addr sequence 0, 4, 8…; id_instr = 0x2008_0005, id_op = 6'b001000, id_pc4 = 4 one edge after the first ack.
REQ-032 id_ready = 0 for 3 cycles with ack = 1 -> after one extra word is captured, state = FULL and imem_req = 0; IF/ID is held; on id_ready = 1 the words emerge in order with no loss or duplication.
REQ-033 Request at 0x10 with ack withheld; redirect_pc = 0x43 -> DRAIN; imem_addr stays 0x10 until ack; that word is discarded; the next request is at 0x40.
REQ-034 Redirect on the same cycle as ack at 0x20, target 0x100 -> id_valid = 0 next cycle; the next imem_addr is 0x100.
REQ-035 pc = 0xFFFF_FFFC, ack -> id_pc4 = 0 and the next imem_addr = 0.
REQ-036 rst_n low during DRAIN -> all outputs take their reset values asynchronously; the first request after release is at RESET_PC.
